// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b - bin, one bit per clock LSB first, start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d_bit, nb;
  logic [WIDTH-1:0] res_next;
  assign d_bit    = sa[0] ^ sb[0] ^ borrow;
  assign nb       = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  assign res_next = {d_bit, res[WIDTH-1:1]};
  assign busy     = (state == RUN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= res_next;
          borrow <= nb;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= res_next;
            bout  <= nb;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        // DONE counts as not busy, so a new start is accepted straight away
        default: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks on a 4-bit instance and a reference-model sweep on an 8-bit one.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  // One 4-bit op: lat = edges after the accepting edge until done is seen.
  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     output int lat, output logic [3:0] d, output logic bo,
                     output int busy_cnt, output int done_cnt);
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    lat = -1; d = 'x; bo = 1'bx; busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (busy4) busy_cnt++;
      if (done4) begin
        done_cnt++;
        if (lat < 0) begin lat = k - 1; d = diff4; bo = bout4; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy4, done4, diff4, bout4} !== 7'b0) begin
      failures++;
      $display("FAIL reset4 got busy=%b done=%b diff=%h bout=%b want all 0", busy4, done4, diff4, bout4);
    end
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'b0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b diff=%h bout=%b want all 0", busy8, done8, diff8, bout8);
    end
  endtask

  task automatic test_basic;
    int lat, bc, dc; logic [3:0] d; logic bo;
    go4(4'd9, 4'd3, 1'b0, lat, d, bo, bc, dc);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++;
    if ({bo, d} !== 5'h06) begin failures++; $display("FAIL basic_result got bout=%b diff=%h want 0/6", bo, d); end
    checks++;
    if (bc !== 4) begin failures++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL basic_done_count got %0d want 1", dc); end
  endtask

  task automatic test_borrow;
    int lat, bc, dc; logic [3:0] d; logic bo;
    go4(4'd3, 4'd9, 1'b0, lat, d, bo, bc, dc);
    checks++;
    if ({bo, d} !== 5'h1A || lat !== 4) begin
      failures++; $display("FAIL borrow_3m9 got bout=%b diff=%h lat=%0d want 1/a lat 4", bo, d, lat);
    end
    go4(4'd0, 4'd0, 1'b1, lat, d, bo, bc, dc);
    checks++;
    if ({bo, d} !== 5'h1F || lat !== 4) begin
      failures++; $display("FAIL borrow_bin got bout=%b diff=%h lat=%0d want 1/f lat 4", bo, d, lat);
    end
    checks++;
    if ({bout4, diff4} !== 5'h1F) begin
      failures++; $display("FAIL result_hold got bout=%b diff=%h want 1/f", bout4, diff4);
    end
  endtask

  task automatic test_reset_mid;
    int dc;
    @(negedge clk);
    a4 = 4'd12; b4 = 4'd5; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got %b want 1", busy4); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, diff4, bout4} !== 7'b0) begin
      failures++;
      $display("FAIL midreset_async got busy=%b done=%b diff=%h bout=%b want all 0", busy4, done4, diff4, bout4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done4 || busy4) dc++;
    end
    checks++;
    if (dc !== 0) begin failures++; $display("FAIL midreset_no_done got %0d active cycles want 0", dc); end
  endtask

  task automatic test_ignore_start;
    int lat, dc; logic [3:0] d; logic bo;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd7; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = -1; dc = 0; d = 'x; bo = 1'bx;
    for (int k = 3; k <= 14; k++) begin
      if (done4) begin
        dc++;
        if (lat < 0) begin lat = k - 1; d = diff4; bo = bout4; end
      end
      @(negedge clk);
    end
    checks++;
    if ({bo, d} !== 5'h00 || lat !== 4) begin
      failures++; $display("FAIL ignore_result got bout=%b diff=%h lat=%0d want 0/0 lat 4", bo, d, lat);
    end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL ignore_done_count got %0d want 1", dc); end
  endtask

  task automatic test_back_to_back;
    int t[2]; logic [4:0] r[2]; int n;
    n = 0; t[0] = -1; t[1] = -1; r[0] = 'x; r[1] = 'x;
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin a4 = 4'd2; b4 = 4'd5; end
      if (k == 6) start4 = 1'b0;
      if (done4) begin
        if (n < 2) begin t[n] = k; r[n] = {bout4, diff4}; end
        n++;
      end
    end
    checks++;
    if (n !== 2) begin failures++; $display("FAIL b2b_done_count got %0d want 2", n); end
    checks++;
    if (t[0] !== 5 || t[1] !== 10) begin
      failures++; $display("FAIL b2b_timing got %0d,%0d want 5,10", t[0], t[1]);
    end
    checks++;
    if (r[0] !== 5'h0E) begin failures++; $display("FAIL b2b_first got %h want 0e", r[0]); end
    checks++;
    if (r[1] !== 5'h1D) begin failures++; $display("FAIL b2b_second got %h want 1d", r[1]); end
  endtask

  task automatic test_w8_model;
    logic [7:0] a, b; logic bin; logic [8:0] exp; int lat;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin a = 8'd0; b = 8'd255; bin = 1'b1; end
      else if (i == 1) begin a = 8'd255; b = 8'd0; bin = 1'b0; end
      else if (i == 2) begin a = 8'd128; b = 8'd128; bin = 1'b1; end
      else begin a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); end
      exp = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      @(negedge clk);
      a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bin;
      lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        if (done8) begin
          lat = k - 1;
          checks++;
          if ({bout8, diff8} !== exp) begin
            failures++; $display("FAIL w8_result op=%0d a=%0d b=%0d bin=%b got %h want %h", i, a, b, bin, {bout8, diff8}, exp);
          end
        end else begin
          @(negedge clk);
        end
      end
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL w8_latency op=%0d got %0d want 8", i, lat); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_basic;
    test_borrow;
    test_reset_mid;
    test_ignore_start;
    test_back_to_back;
    test_w8_model;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
